// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory handshake, control from hazard/EX units,
// and the IF/ID register outputs toward decode.
interface fetch_if;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] instruction;
  logic        valid;

  modport master (
    input  freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
    output imem_req, imem_addr, PC_out, instruction, valid
  );

  modport slave (
    output freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
    input  imem_req, imem_addr, PC_out, instruction, valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: owns the PC, runs the imem req/ack
// handshake, and applies freeze (via a one-entry skid buffer) and branch flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic clk,
  input  logic rst,
  fetch_if.master bus
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr;
  logic        r_valid;

  logic        w_req;
  logic        w_ack;
  logic [31:0] w_pc_next;

  // The request drops with reset itself, not one edge later.
  assign w_req     = !rst && ((r_state == ST_REQ) || (r_state == ST_DRAIN));
  assign w_ack     = w_req && bus.imem_ack;
  assign w_pc_next = r_pc + PC_STEP;

  // In DRAIN the PC is untouched until the ack, so it still holds the old address.
  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.PC_out      = r_pc_out;
  assign bus.instruction = r_instr;
  assign bus.valid       = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_REQ;
      r_pc         <= RESET_PC;
      r_target     <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
      r_pc_out     <= 32'd0;
      r_instr      <= 32'd0;
      r_valid      <= 1'b0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (bus.branch_taken) begin
            r_instr      <= 32'd0;
            r_valid      <= 1'b0;
            r_skid_pc    <= 32'd0;
            r_skid_instr <= 32'd0;
            if (w_ack) begin
              r_pc <= bus.branch_addr;
            end else begin
              r_target <= bus.branch_addr;
              r_state  <= ST_DRAIN;
            end
          end else if (w_ack) begin
            r_pc <= w_pc_next;
            if (bus.freeze) begin
              r_skid_pc    <= w_pc_next;
              r_skid_instr <= bus.imem_rdata;
              r_state      <= ST_HOLD;
            end else begin
              r_pc_out <= w_pc_next;
              r_instr  <= bus.imem_rdata;
              r_valid  <= 1'b1;
            end
          end else if (!bus.freeze) begin
            r_instr <= 32'd0;
            r_valid <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (bus.branch_taken) begin
            r_instr      <= 32'd0;
            r_valid      <= 1'b0;
            r_skid_pc    <= 32'd0;
            r_skid_instr <= 32'd0;
            r_pc         <= bus.branch_addr;
            r_state      <= ST_REQ;
          end else if (!bus.freeze) begin
            r_pc_out     <= r_skid_pc;
            r_instr      <= r_skid_instr;
            r_valid      <= 1'b1;
            r_skid_pc    <= 32'd0;
            r_skid_instr <= 32'd0;
            r_state      <= ST_REQ;
          end
        end

        ST_DRAIN: begin
          r_instr <= 32'd0;
          r_valid <= 1'b0;
          // A branch arriving with the ack is the newest target and wins.
          if (w_ack) begin
            r_pc    <= bus.branch_taken ? bus.branch_addr : r_target;
            r_state <= ST_REQ;
          end else if (bus.branch_taken) begin
            r_target <= bus.branch_addr;
          end
        end

        default: r_state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_fetch_stage;

  logic clk;
  logic rst;
  fetch_if bus ();

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model: the fetch PC, instructions parked while decode is
  // frozen, and a pending redirect waiting for the old request to finish.
  logic [31:0] m_pc;
  entry_t      m_parked[$];
  bit          m_redirect;
  logic [31:0] m_target;
  logic [31:0] m_out_pc;
  logic [31:0] m_out_instr;
  logic        m_out_valid;

  int total;
  int bad;

  function automatic bit m_req();
    return (m_parked.size() == 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc        = 32'h0;
    m_parked.delete();
    m_redirect  = 1'b0;
    m_target    = 32'h0;
    m_out_pc    = 32'h0;
    m_out_instr = 32'h0;
    m_out_valid = 1'b0;
  endtask

  task automatic model_step(input bit f, input bit b, input logic [31:0] ba,
                            input bit a, input logic [31:0] rd);
    bit got;
    entry_t e;
    got = a && m_req();
    if (b) begin
      m_out_instr = 32'h0;
      m_out_valid = 1'b0;
      if (m_redirect) begin
        if (got) begin
          m_pc = ba;
          m_redirect = 1'b0;
        end else begin
          m_target = ba;
        end
      end else if (m_parked.size() != 0 || got) begin
        m_pc = ba;
      end else begin
        m_redirect = 1'b1;
        m_target   = ba;
      end
      m_parked.delete();
    end else if (m_redirect) begin
      m_out_instr = 32'h0;
      m_out_valid = 1'b0;
      if (got) begin
        m_pc = m_target;
        m_redirect = 1'b0;
      end
    end else if (m_parked.size() != 0) begin
      if (!f) begin
        e = m_parked.pop_front();
        m_out_pc    = e.pc;
        m_out_instr = e.instr;
        m_out_valid = 1'b1;
      end
    end else if (got) begin
      if (f) begin
        m_parked.push_back({m_pc + 32'd4, rd});
      end else begin
        m_out_pc    = m_pc + 32'd4;
        m_out_instr = rd;
        m_out_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!f) begin
      m_out_instr = 32'h0;
      m_out_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("imem_req", {31'd0, bus.imem_req}, {31'd0, m_req()});
    if (m_req()) check("imem_addr", bus.imem_addr, m_pc);
    check("valid", {31'd0, bus.valid}, {31'd0, m_out_valid});
    check("instruction", bus.instruction, m_out_instr);
    check("PC_out", bus.PC_out, m_out_pc);
  endtask

  // One clock: drive at the falling edge, clock it in, compare at the next falling edge.
  task automatic cycle(input bit f, input bit b, input logic [31:0] ba,
                       input bit a, input logic [31:0] rd);
    bus.freeze       = f;
    bus.branch_taken = b;
    bus.branch_addr  = ba;
    bus.imem_ack     = a;
    bus.imem_rdata   = rd;
    model_step(f, b, ba, a, rd);
    @(negedge clk);
    compare_all();
    if (bus.valid)
      $display("txn t=%0t PC_out=%h instr=%h", $time, bus.PC_out, bus.instruction);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.freeze = 0; bus.branch_taken = 0; bus.branch_addr = 0;
    bus.imem_ack = 0; bus.imem_rdata = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_req_lit", {31'd0, bus.imem_req}, 32'd1);
    check("rst_addr_lit", bus.imem_addr, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    bit f, b, a;
    logic [31:0] ba;
    total = 0;
    bad   = 0;
    model_reset();
    rst = 1'b1;

    // Zero-wait stream
    do_reset();
    cycle(0, 0, 0, 1, 32'hA000_0000);
    check("zw0_instr", bus.instruction, 32'hA000_0000);
    check("zw0_pc", bus.PC_out, 32'd4);
    cycle(0, 0, 0, 1, 32'hA000_0001);
    check("zw1_pc", bus.PC_out, 32'd8);
    cycle(0, 0, 0, 1, 32'hA000_0002);
    check("zw2_instr", bus.instruction, 32'hA000_0002);
    check("zw2_pc", bus.PC_out, 32'd12);
    check("zw2_valid", {31'd0, bus.valid}, 32'd1);

    // Wait states on address 8
    do_reset();
    cycle(0, 0, 0, 1, 32'h1);
    cycle(0, 0, 0, 1, 32'h2);
    cycle(0, 0, 0, 0, 32'h0);
    check("ws_addr", bus.imem_addr, 32'd8);
    check("ws_bubble", {31'd0, bus.valid}, 32'd0);
    cycle(0, 0, 0, 0, 32'h0);
    check("ws_addr2", bus.imem_addr, 32'd8);
    cycle(0, 0, 0, 1, 32'hB0B0_B0B0);
    check("ws_instr", bus.instruction, 32'hB0B0_B0B0);
    check("ws_pc", bus.PC_out, 32'd12);

    // Freeze while data returns
    do_reset();
    cycle(0, 0, 0, 1, 32'hA0);
    cycle(1, 0, 0, 1, 32'hD00D);
    check("fz_hold_instr", bus.instruction, 32'hA0);
    check("fz_req", {31'd0, bus.imem_req}, 32'd0);
    cycle(0, 0, 0, 0, 32'h0);
    check("fz_instr", bus.instruction, 32'hD00D);
    check("fz_pc", bus.PC_out, 32'd8);
    check("fz_addr", bus.imem_addr, 32'd8);

    // Branch during outstanding request
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 32'h10 + i);
    cycle(0, 1, 32'h100, 0, 32'h0);
    check("br_addr_old", bus.imem_addr, 32'd16);
    check("br_valid", {31'd0, bus.valid}, 32'd0);
    cycle(0, 0, 0, 0, 32'h0);
    check("br_addr_old2", bus.imem_addr, 32'd16);
    cycle(0, 0, 0, 1, 32'hDEAD);
    check("br_drop", bus.instruction, 32'h0);
    check("br_addr_new", bus.imem_addr, 32'h100);

    // Branch + freeze in HOLD
    do_reset();
    cycle(1, 0, 0, 1, 32'hBAD0);
    cycle(1, 1, 32'h200, 0, 32'h0);
    check("bh_valid", {31'd0, bus.valid}, 32'd0);
    check("bh_addr", bus.imem_addr, 32'h200);
    cycle(0, 0, 0, 1, 32'h7777);
    check("bh_pc", bus.PC_out, 32'h204);

    // PC wrap
    do_reset();
    cycle(0, 1, 32'hFFFF_FFFC, 1, 32'h0);
    cycle(0, 0, 0, 1, 32'h5555);
    check("wrap_pc", bus.PC_out, 32'h0);
    check("wrap_addr", bus.imem_addr, 32'h0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom;
      f  = (r[1:0] == 2'b00);
      b  = (r[7:4] == 4'h0);
      a  = (r[9:8] != 2'b00);
      ba = $urandom;
      ba[1:0] = 2'b00;
      if (r[12:10] == 3'b000) ba = 32'hFFFF_FFF0 | {28'd0, ba[3:0]};
      cycle(f, b, ba, a, $urandom);
    end

    // Reset asserted mid-fetch drops the request immediately
    #2;
    rst = 1'b1;
    #1;
    check("rst_req_async", {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid_async", {31'd0, bus.valid}, 32'd0);
    check("rst_instr_async", bus.instruction, 32'd0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 5-stage ARM-subset pipeline. It is the producer of the PC and instruction words consumed by the decode stage. It owns the PC and issues requests to a variable-latency instruction memory over a req/ack handshake. It also applies hazard freeze and branch flush, so decode only ever sees whole, in-order, correctly-flushed instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment between sequential instructions.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
freeze  in  1  hazard stall from the hazard unit; hold IF/ID contents.
branch_taken  in  1  branch resolved taken in EX; flush and redirect.
branch_addr  in  32  branch target.
imem_req  out  1  instruction-memory request.
imem_addr  out  32  fetch address; stable while imem_req=1 until ack.
imem_ack  in  1  memory returns imem_rdata this cycle.
imem_rdata  in  32  fetched instruction word.
PC_out  out  32  PC+PC_STEP of the instruction held in IF/ID.
instruction  out  32  IF/ID instruction word.
valid  out  1  IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=REQ, IF/ID PC_out=0, instruction=0, valid=0, skid buffer empty. imem_req drops combinationally with rst and is 1 in the first cycle after reset release.
- Handshake: imem_req=1 in REQ and DRAIN. imem_addr=pc in REQ and the latched old address in DRAIN. imem_ack is sampled only while imem_req=1. Ack in the same cycle as request assertion (zero-wait) is legal. The address must not change between request and ack.
- Priority per edge: rst > branch_taken > freeze > normal.
- State REQ:
  - ack & !freeze: IF/ID <= {pc+PC_STEP, rdata, valid=1}; pc <= pc+PC_STEP; stay in REQ. Back-to-back zero-wait acks give 1 instruction per cycle.
  - ack & freeze: rdata and pc+PC_STEP go to the skid buffer; IF/ID holds; pc += PC_STEP; go to HOLD.
  - !ack & !freeze: IF/ID <= bubble {PC_out unchanged, instruction=0, valid=0}.
  - !ack & freeze: IF/ID holds.
- State HOLD (imem_req=0):
  - freeze=1: IF/ID and buffer hold.
  - freeze=0: IF/ID <= buffer with valid=1; buffer cleared; go to REQ.
- Branch (branch_taken=1, any state):
  - IF/ID <= bubble (instruction=0, valid=0); skid buffer discarded; freeze ignored that cycle.
  - REQ with ack this cycle, or HOLD: pc <= branch_addr; go to REQ. Returned data is dropped.
  - REQ without ack: the outstanding request must complete. Latch target; go to DRAIN, which keeps imem_addr at the old address.
  - DRAIN: a newer branch_taken overwrites the latched target (latest wins).
- State DRAIN:
  - ack: data dropped; pc <= latched target; go to REQ.
  - IF/ID stays bubble throughout.
- Arithmetic: 32-bit modulo; pc wraps 32'hFFFF_FFFC -> 0 silently.
- The skid buffer is exactly one entry; no state ever requires more.

Test Plan:
- Reset: rst=1 mid-fetch -> imem_req=0 immediately; after release, imem_addr=0, valid=0, instruction=0.
- Zero-wait stream: ack=1 every cycle, rdata=A0,A1,A2 -> IF/ID shows A0/PC_out=4, A1/8, A2/12 on consecutive cycles, valid=1.
- Wait states: ack delayed 2 cycles on addr 8 -> imem_addr stays 8, two bubbles (valid=0, instruction=0), then instruction at PC_out=12.
- Freeze with ack: freeze=1 while data D returns for addr 4 -> IF/ID unchanged, imem_req=0. After freeze falls, the next edge gives instruction=D, PC_out=8, and fetch resumes at 8.
- Branch during outstanding request: req at addr 16 without ack, branch_taken=1 to 0x100; ack arrives 2 cycles later -> data discarded, imem_addr stays 16 until ack, next request at 0x100, valid=0 throughout.
- Branch+freeze together in HOLD: buffer dropped, valid=0, next imem_addr=branch_addr.
